// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared encodings for the MIPS hazard logic. Holds the
//                Tuse/Tnew timing codes, default mult/div latencies, the
//                MD opcode/funct constants (also used by the decoder) and a
//                per-source hazard compare helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Timing codes: cycles until a value is needed (Tuse) or produced (Tnew).
  typedef logic [1:0] stage_time_t;

  localparam stage_time_t TUSE_NOW  = 2'd0;
  localparam stage_time_t TUSE_ONE  = 2'd1;
  localparam stage_time_t TUSE_TWO  = 2'd2;
  localparam stage_time_t TUSE_NONE = 2'd3;

  localparam stage_time_t TNEW_NOW  = 2'd0;
  localparam stage_time_t TNEW_ONE  = 2'd1;
  localparam stage_time_t TNEW_TWO  = 2'd2;

  // Default busy windows of the multi-cycle MD unit.
  localparam int MULT_LAT_DFLT = 5;
  localparam int DIV_LAT_DFLT  = 10;

  // Width of the MD busy down-counter; must hold the longest latency.
  localparam int MD_CNT_W = 4;

  // Which kind of MD operation an issue starts.
  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_kind_e;

  // R-type opcode and MD funct codes.
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // True when an instruction touches the MD unit or HI/LO.
  function automatic logic is_md_instr(input logic [5:0] opcode,
                                       input logic [5:0] funct);
    logic r_type;
    r_type = (opcode == OP_SPECIAL);
    return r_type && ((funct == FUNCT_MFHI)  || (funct == FUNCT_MTHI) ||
                      (funct == FUNCT_MFLO)  || (funct == FUNCT_MTLO) ||
                      (funct == FUNCT_MULT)  || (funct == FUNCT_MULTU) ||
                      (funct == FUNCT_DIV)   || (funct == FUNCT_DIVU));
  endfunction

  // A source register stalls when a producer in E or M will not have its
  // result ready by the time D needs it. Register 0 is hardwired and never
  // creates a dependency.
  function automatic logic src_hazard(input logic [4:0]  src_addr,
                                      input stage_time_t tuse,
                                      input logic [4:0]  e_wa,
                                      input stage_time_t e_tnew,
                                      input logic [4:0]  m_wa,
                                      input stage_time_t m_tnew);
    logic hit_e;
    logic hit_m;
    hit_e = (src_addr == e_wa) && (e_tnew > tuse);
    hit_m = (src_addr == m_wa) && (m_tnew > tuse);
    return (src_addr != 5'd0) && (hit_e || hit_m);
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/md_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_tracker
//  Description : Tracks the busy window of the multi-cycle mult/div unit with
//                a down-counter loaded on issue. md_busy covers the issue
//                cycle itself plus every cycle the counter is non-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DFLT,
  parameter int DIV_LAT  = DIV_LAT_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_md_start,
  input  logic i_md_is_div,
  output logic o_md_busy
);

  localparam logic [MD_CNT_W-1:0] c_mult_load = MD_CNT_W'(MULT_LAT);
  localparam logic [MD_CNT_W-1:0] c_div_load  = MD_CNT_W'(DIV_LAT);
  localparam logic [MD_CNT_W-1:0] c_one       = MD_CNT_W'(1);

  logic [MD_CNT_W-1:0] r_md_cnt;
  logic                w_cnt_zero;
  logic [MD_CNT_W-1:0] w_load_val;
  md_kind_e            w_kind;

  assign w_cnt_zero = (r_md_cnt == '0);
  assign w_kind     = i_md_is_div ? MD_DIV : MD_MULT;
  assign w_load_val = (w_kind == MD_DIV) ? c_div_load : c_mult_load;

  // Load on a fresh issue; a start while already busy is ignored and the
  // window keeps counting down so the original operation finishes on time.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (i_md_start && w_cnt_zero) begin
      r_md_cnt <= w_load_val;
    end else if (!w_cnt_zero) begin
      r_md_cnt <= r_md_cnt - c_one;
    end
  end

  // Busy in the issue cycle too, so a HI/LO reader right behind is held.
  assign o_md_busy = i_md_start | ~w_cnt_zero;

endmodule : md_busy_tracker
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl
//  Description : Pipeline hazard controller for the five-stage MIPS core.
//                Compares D-stage Tuse against E/M Tnew, holds HI/LO users
//                while the MD unit is busy, drives fetch/decode enables and
//                the E-stage bubble, and counts stalled cycles (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DFLT,
  parameter int DIV_LAT  = DIV_LAT_DFLT,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs_addr,
  input  logic [4:0]       D_rt_addr,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  output logic             I_EN,
  output logic             D_EN,
  output logic             E_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic             w_md_busy;
  logic             w_rs_hazard;
  logic             w_rt_hazard;
  logic             w_md_hazard;
  logic             w_stall;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] r_stall_cnt;

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_tracker (
    .clk         (clk),
    .reset       (reset),
    .i_md_start  (E_md_start),
    .i_md_is_div (E_md_is_div),
    .o_md_busy   (w_md_busy)
  );

  // Data hazards are purely combinational: the upstream pipeline lowers
  // Tnew as the producer advances, so the stall clears on its own.
  always_comb begin
    w_rs_hazard = src_hazard(D_rs_addr, D_Tuse_rs, E_wa, E_Tnew, M_wa, M_Tnew);
    w_rt_hazard = src_hazard(D_rt_addr, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew);
    w_md_hazard = D_is_md & w_md_busy;
    w_stall     = w_rs_hazard | w_rt_hazard | w_md_hazard;
  end

  assign w_cnt_sat = &r_stall_cnt;

  // Count every stalled cycle once, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  assign I_EN      = ~w_stall;
  assign D_EN      = ~w_stall;
  assign E_clr     = w_stall;
  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

endmodule : stall_ctrl
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stall_ctrl
//  Description : Directed self-checking bench for stall_ctrl. The counter is
//                built 4 bits wide so saturation is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [4:0]    D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]    D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic          D_is_md, E_md_start, E_md_is_div;
  logic          I_EN, D_EN, E_clr, md_busy;
  logic [CW-1:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs_addr  (D_rs_addr),
    .D_rt_addr  (D_rt_addr),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_is_md    (D_is_md),
    .E_wa       (E_wa),
    .E_Tnew     (E_Tnew),
    .M_wa       (M_wa),
    .M_Tnew     (M_Tnew),
    .E_md_start (E_md_start),
    .E_md_is_div(E_md_is_div),
    .I_EN       (I_EN),
    .D_EN       (D_EN),
    .E_clr      (E_clr),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    D_is_md = 1'b0; E_wa = 5'd0; E_Tnew = 2'd0; M_wa = 5'd0; M_Tnew = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    D_rs_addr = 0; D_rt_addr = 0; D_Tuse_rs = 0; D_Tuse_rt = 0; D_is_md = 0;
    E_wa = 0; E_Tnew = 0; M_wa = 0; M_Tnew = 0; E_md_start = 0; E_md_is_div = 0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (I_EN !== 1'b1) begin n_fail++; $display("FAIL reset_I_EN got %b exp 1", I_EN); end
    n_cmp++; if (D_EN !== 1'b1) begin n_fail++; $display("FAIL reset_D_EN got %b exp 1", D_EN); end
    n_cmp++; if (E_clr !== 1'b0) begin n_fail++; $display("FAIL reset_E_clr got %b exp 0", E_clr); end
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy got %b exp 0", md_busy); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    D_rs_addr = 5'd8; D_Tuse_rs = 2'd0; E_wa = 5'd8; E_Tnew = 2'd2;
    #1;
    n_cmp++; if (I_EN !== 1'b0) begin n_fail++; $display("FAIL lw_use_c0_I_EN got %b exp 0", I_EN); end
    n_cmp++; if (E_clr !== 1'b1) begin n_fail++; $display("FAIL lw_use_c0_E_clr got %b exp 1", E_clr); end
    tick();
    E_wa = 5'd0; E_Tnew = 2'd0; M_wa = 5'd8; M_Tnew = 2'd1;
    #1;
    n_cmp++; if (D_EN !== 1'b0) begin n_fail++; $display("FAIL lw_use_c1_D_EN got %b exp 0", D_EN); end
    tick();
    M_wa = 5'd0; M_Tnew = 2'd0;
    #1;
    n_cmp++; if (I_EN !== 1'b1) begin n_fail++; $display("FAIL lw_use_c2_I_EN got %b exp 1", I_EN); end
    n_cmp++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL lw_use_cnt got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    D_rs_addr = 5'd0; D_Tuse_rs = 2'd0; D_rt_addr = 5'd0; D_Tuse_rt = 2'd0;
    E_wa = 5'd0; E_Tnew = 2'd2;
    #1;
    n_cmp++; if (I_EN !== 1'b1) begin n_fail++; $display("FAIL zero_reg_I_EN got %b exp 1", I_EN); end
    n_cmp++; if (E_clr !== 1'b0) begin n_fail++; $display("FAIL zero_reg_E_clr got %b exp 0", E_clr); end
  endtask

  task automatic test_tuse_boundary();
    do_reset();
    D_rs_addr = 5'd4; D_Tuse_rs = 2'd1; E_wa = 5'd4; E_Tnew = 2'd1;
    #1;
    n_cmp++; if (E_clr !== 1'b0) begin n_fail++; $display("FAIL tnew_eq_tuse got %b exp 0", E_clr); end
    E_Tnew = 2'd2;
    #1;
    n_cmp++; if (E_clr !== 1'b1) begin n_fail++; $display("FAIL tnew_gt_tuse got %b exp 1", E_clr); end
    idle();
    D_rt_addr = 5'd7; D_Tuse_rt = 2'd1; M_wa = 5'd7; M_Tnew = 2'd2;
    #1;
    n_cmp++; if (D_EN !== 1'b0) begin n_fail++; $display("FAIL rt_m_hazard got %b exp 0", D_EN); end
    D_Tuse_rt = 2'd3;
    #1;
    n_cmp++; if (D_EN !== 1'b1) begin n_fail++; $display("FAIL rt_tuse_none got %b exp 1", D_EN); end
    D_Tuse_rt = 2'd1; M_wa = 5'd6;
    #1;
    n_cmp++; if (D_EN !== 1'b1) begin n_fail++; $display("FAIL rt_addr_differs got %b exp 1", D_EN); end
    idle();
  endtask

  task automatic test_mult();
    do_reset();
    E_md_start = 1'b1; E_md_is_div = 1'b0;
    #1;
    n_cmp++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL mult_t_busy got %b exp 1", md_busy); end
    n_cmp++; if (I_EN !== 1'b1) begin n_fail++; $display("FAIL mult_t_I_EN got %b exp 1", I_EN); end
    tick();
    E_md_start = 1'b0; D_is_md = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_cmp++; if (E_clr !== 1'b1) begin n_fail++; $display("FAIL mult_stall_t+%0d got %b exp 1", k, E_clr); end
      tick();
    end
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mult_t+6_busy got %b exp 0", md_busy); end
    n_cmp++; if (I_EN !== 1'b1) begin n_fail++; $display("FAIL mult_t+6_I_EN got %b exp 1", I_EN); end
    n_cmp++; if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL mult_cnt got %0d exp 5", stall_cnt); end
    idle();
  endtask

  task automatic test_div_window();
    do_reset();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_is_div = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      n_cmp++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL div_busy_t+%0d got %b exp 1", k, md_busy); end
      tick();
    end
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL div_t+11_busy got %b exp 0", md_busy); end
  endtask

  task automatic test_start_while_busy();
    do_reset();
    E_md_start = 1'b1; E_md_is_div = 1'b0;
    tick();
    E_md_start = 1'b0;
    tick();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_is_div = 1'b0;
    tick(); tick(); tick();
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_t+6 got %b exp 0", md_busy); end
  endtask

  task automatic test_div_reset();
    do_reset();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    tick();
    E_md_start = 1'b0; E_md_is_div = 1'b0; D_is_md = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL div_rst_pre_cnt got %0d exp 2", stall_cnt); end
    tick();
    reset = 1'b1; D_is_md = 1'b0;
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL div_rst_busy got %b exp 0", md_busy); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL div_rst_cnt got %0d exp 0", stall_cnt); end
    reset = 1'b0; E_md_start = 1'b1; E_md_is_div = 1'b1;
    tick();
    reset = 1'b1; E_md_start = 1'b0; E_md_is_div = 1'b0;
    #1;
    n_cmp++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_over_start got %b exp 0", md_busy); end
  endtask

  task automatic test_combined();
    do_reset();
    E_md_start = 1'b1; E_md_is_div = 1'b0;
    tick();
    E_md_start = 1'b0; D_is_md = 1'b1;
    D_rs_addr = 5'd5; D_Tuse_rs = 2'd0; E_wa = 5'd5; E_Tnew = 2'd2;
    D_rt_addr = 5'd6; D_Tuse_rt = 2'd0; M_wa = 5'd6; M_Tnew = 2'd1;
    #1;
    n_cmp++; if (E_clr !== 1'b1) begin n_fail++; $display("FAIL combo_E_clr got %b exp 1", E_clr); end
    tick();
    n_cmp++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL combo_cnt got %0d exp 1", stall_cnt); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    D_rs_addr = 5'd9; D_Tuse_rs = 2'd0; E_wa = 5'd9; E_Tnew = 2'd2;
    for (int k = 0; k < 15; k++) tick();
    n_cmp++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_reach got %0d exp 15", stall_cnt); end
    tick();
    n_cmp++; if (stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
    n_cmp++; if (E_clr !== 1'b1) begin n_fail++; $display("FAIL sat_E_clr got %b exp 1", E_clr); end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_tuse_boundary();
    test_mult();
    test_div_window();
    test_start_while_busy();
    test_div_reset();
    test_combined();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_stall_ctrl
`default_nettype wire
